// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared state encoding and result-width helper for seq_mul
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign bit plus 2*(w-1) magnitude bits
  function automatic int res_width(input int w);
    return 2 * w - 1;
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// rtl/seq_mul_dp.sv - shift-add datapath: operand registers, accumulator, counter, zero-normalised result
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          step,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic [res_width(WIDTH)-1:0]   r,
  output logic                          last
);

  localparam int M  = WIDTH - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(WIDTH);

  logic [AW-1:0] mcand;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [M-1:0]  mult;
  logic [CW-1:0] cnt;
  logic          sign;

  assign acc_next = acc + (mult[0] ? mcand : '0);
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      r     <= '0;
    end else if (load) begin
      mcand <= {{M{1'b0}}, a[M-1:0]};
      mult  <= b[M-1:0];
      sign  <= a[WIDTH-1] ^ b[WIDTH-1];
      acc   <= '0;
      cnt   <= CW'(M);
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      cnt   <= cnt - CW'(1);
      // A zero magnitude always yields +0, even for negative-zero operands
      if (last) r <= {sign & (|acc_next), acc_next};
    end
  end

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - sequential sign-magnitude multiplier: IDLE/BUSY/DONE control around seq_mul_dp
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  output logic [res_width(WIDTH)-1:0] R,
  output logic                        busy,
  output logic                        done
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   step;
  logic   last;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        // start during DONE chains straight into the next operation
        if (start) begin
          load       = 1'b1;
          state_next = ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_BUSY);
  assign done = (state == ST_DONE);

  seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (A),
    .b    (B),
    .r    (R),
    .last (last)
  );

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits, sign-magnitude (MSB = sign, WIDTH-1 magnitude bits); legal range 2..16.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a multiply with current A/B.
REQ-005 SHALL have port A, input, WIDTH, multiplicand, sign-magnitude.
REQ-006 SHALL have port B, input, WIDTH, multiplier, sign-magnitude.
REQ-007 SHALL have port R, output, 2*WIDTH-1, product: R[2*WIDTH-2] = sign, lower 2*(WIDTH-1) bits = magnitude.
REQ-008 SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking R newly valid.

Function
REQ-010 SHALL implement states IDLE, BUSY, DONE; state encoding fixed in the shared package.
REQ-011 IDLE: start=1 at an edge SHALL capture A and B into internal registers, clear the accumulator, load counter with WIDTH-1, enter BUSY.
REQ-012 BUSY: each edge SHALL examine one multiplier magnitude bit, LSB first; if set, add the shifted multiplicand magnitude into the accumulator.
REQ-013 BUSY SHALL last exactly WIDTH-1 edges; on the edge processing the last magnitude bit, R SHALL be loaded and state SHALL go to DONE.
REQ-014 Latency: start sampled at edge E0 -> done=1 in the cycle after edge E(WIDTH-1); WIDTH=3 gives 2 edges.
REQ-015 DONE: done=1 for exactly one cycle, busy=0; next edge returns to IDLE unless start=1, in which case REQ-011 capture occurs and state enters BUSY (back-to-back).
REQ-016 busy SHALL be 1 only in BUSY; done SHALL be 1 only in DONE.
REQ-017 start while BUSY SHALL be ignored; A/B changes while BUSY SHALL not affect the result.
REQ-018 Product sign SHALL be A[WIDTH-1] XOR B[WIDTH-1].
REQ-019 If the product magnitude is zero (either magnitude zero, including negative-zero operands), R SHALL be all zeros (sign forced 0).
REQ-020 Magnitude SHALL be exact; accumulator width 2*(WIDTH-1), no overflow possible.
REQ-021 R SHALL hold its value from DONE entry until the next DONE entry; it SHALL not change during a following BUSY.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, R=0, busy=0, done=0, counter and accumulator 0; rst has priority over start.
REQ-023 rst during BUSY SHALL abandon the operation; no done pulse SHALL follow.

Structure
REQ-024 Package seq_mul_pkg SHALL hold the state encoding constants and the result-width helper (2*WIDTH-1).
REQ-025 Datapath SHALL be one sub-module, seq_mul_dp (shift register, accumulator, counter, zero-normalise); FSM and handshake stay in seq_mul.

Verification
REQ-026 WIDTH=3, A=011, B=111, start pulse -> done after 2 edges, R=11001 (-9).
REQ-027 WIDTH=3, A=110, B=101 -> R=00010 (+2); A=100, B=011 -> R=00000 (negative zero normalised).
REQ-028 WIDTH=4, A=0111, B=1111 -> done after 3 edges, R=1110001 (-49).
REQ-029 WIDTH=3, start held high across BUSY with A/B changed mid-op -> exactly one result for captured operands, then back-to-back second result, done pulses spaced 3 cycles.
REQ-030 rst asserted one edge after start -> busy=0, done never pulses, R=00000; exhaustive WIDTH=3 sweep (all 64 pairs) matches a sign-magnitude reference model.
